// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the core that talks to it:
// FSM state encoding, RV32I load/store funct3 codes and store byte-lane helpers.
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Byte-lane enables for a store of the given width at byte offset off.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_SB:   store_be = 4'b0001 << off;
            F3_SH:   store_be = 4'b0011 << off;
            F3_SW:   store_be = 4'b1111;
            default: store_be = 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data onto every lane it could land in.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            F3_SB:   store_lanes = {4{wdata[7:0]}};
            F3_SH:   store_lanes = {2{wdata[15:0]}};
            default: store_lanes = wdata;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator (core) and the data-memory responder.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_load_align.sv
// Load lane selection and sign/zero extension for RV32I loads (little-endian).
module load_align
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = word_i >> {offset_i, 3'b000};

    // Pick the addressed lane(s) and extend to 32 bits; unsupported codes give 0.
    always_comb begin
        // NOTE: every path assigns data_o (default arm included), so no latch is inferred.
        case (funct3_i)
            F3_LB:   data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   data_o = shifted;
            F3_LBU:  data_o = {24'd0, shifted[7:0]};
            F3_LHU:  data_o = {16'd0, shifted[15:0]};
            default: data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles, then
// performs the access and holds the response until the initiator takes it.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT   = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    logic [31:0] mem_q [DEPTH_WORDS];

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [AW-1:0] idx;
    logic          f3_err_d;
    logic          align_err_d;
    logic          err_d;
    logic          fire_d;
    logic          mem_we_d;
    logic [3:0]    be_d;
    logic [31:0]   lanes_d;
    logic [31:0]   load_data;

    assign idx     = addr_q[AW+1:2];
    assign be_d    = store_be(funct3_q, addr_q[1:0]);
    assign lanes_d = store_lanes(funct3_q, wdata_q);
    assign fire_d  = (state_q == WAIT) && (cnt_q == 4'd0);
    assign err_d   = f3_err_d || align_err_d || (addr_q >= LIMIT);
    // A reset on the commit edge aborts the store along with the transaction.
    assign mem_we_d = rst && fire_d && we_q && !err_d;

    // Classify the captured request: illegal funct3 and misaligned half/word accesses.
    always_comb begin
        f3_err_d    = 1'b0;
        align_err_d = 1'b0;
        if (we_q) begin
            f3_err_d = !(funct3_q inside {F3_SB, F3_SH, F3_SW});
        end else begin
            f3_err_d = !(funct3_q inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        end
        case (funct3_q[1:0])
            2'b01:   align_err_d = addr_q[0];
            2'b10:   align_err_d = (addr_q[1:0] != 2'b00);
            default: align_err_d = 1'b0;
        endcase
    end

    load_align u_load_align (
        .word_i   (mem_q[idx]),
        .funct3_i (funct3_q),
        .offset_i (addr_q[1:0]),
        .data_o   (load_data)
    );

    // Storage: byte-lane writes only, contents survive reset.
    always_ff @(posedge clk) begin
        // NOTE: the memory array has no reset on purpose; that keeps it mappable to RAM.
        if (mem_we_d) begin
            for (int b = 0; b < 4; b++) begin
                if (be_d[b]) mem_q[idx][8*b +: 8] <= lanes_d[8*b +: 8];
            end
        end
    end

    // Transaction FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (bus.req_valid && ready_q) begin
                        we_q     <= bus.req_we;
                        funct3_q <= bus.req_funct3;
                        addr_q   <= bus.req_addr;
                        wdata_q  <= bus.req_wdata;
                        cnt_q    <= LAT_M1;
                        ready_q  <= 1'b0;
                        state_q  <= WAIT;
                    end
                end
                WAIT: begin
                    if (fire_d) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        err_q       <= err_d;
                        rdata_q     <= (err_d || we_q) ? 32'd0 : load_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rdata_q     <= 32'd0;
                        err_q       <= 1'b0;
                        ready_q     <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued on
// acceptance and compared when the responder presents them.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int DEPTH_WORDS = 64;
    localparam int LATENCY     = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       tag;
    } exp_t;

    logic clk;
    logic rst;
    data_mem_responder_if bus_if ();

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .LATENCY     (LATENCY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, queue its expected response, then collect it.
    task automatic send(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input int stall);
        int   lat;
        exp_t e;
        for (int i = 0; i < 20 && !bus_if.req_ready; i++) @(posedge clk) #1;
        check({tag, "_ready"}, {31'd0, bus_if.req_ready}, 32'd1);
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = we;
        bus_if.req_funct3 = f3;
        bus_if.req_addr   = addr;
        bus_if.req_wdata  = wdata;
        @(posedge clk);
        exp_q.push_back('{rdata: exp_rdata, err: exp_err, tag: tag});
        #1;
        bus_if.req_valid  = 1'b0;
        bus_if.req_addr   = 32'hFFFF_FFFF;
        bus_if.req_wdata  = 32'hA5A5_A5A5;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk) #1;
            lat++;
            if (bus_if.rsp_valid) break;
        end
        check({tag, "_valid"}, {31'd0, bus_if.rsp_valid}, 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(LATENCY));
        e = exp_q[0];
        for (int s = 0; s < stall; s++) begin
            @(posedge clk) #1;
            check({tag, "_stall_valid"}, {31'd0, bus_if.rsp_valid}, 32'd1);
            check({tag, "_stall_rdata"}, bus_if.rsp_rdata, e.rdata);
            check({tag, "_stall_ready"}, {31'd0, bus_if.req_ready}, 32'd0);
        end
        e = exp_q.pop_front();
        check({e.tag, "_rdata"}, bus_if.rsp_rdata, e.rdata);
        check({e.tag, "_err"}, {31'd0, bus_if.rsp_err}, {31'd0, e.err});
        bus_if.rsp_ready = 1'b1;
        @(posedge clk) #1;
        bus_if.rsp_ready = 1'b0;
        check({tag, "_done_valid"}, {31'd0, bus_if.rsp_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, bus_if.req_ready}, 32'd1);
    endtask

    initial begin
        rst               = 1'b0;
        bus_if.req_valid  = 1'b0;
        bus_if.req_we     = 1'b0;
        bus_if.req_funct3 = 3'd0;
        bus_if.req_addr   = 32'd0;
        bus_if.req_wdata  = 32'd0;
        bus_if.rsp_ready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, bus_if.req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", bus_if.rsp_rdata, 32'd0);
        check("rst_rsp_err",   {31'd0, bus_if.rsp_err}, 32'd0);
        rst = 1'b1;
        @(posedge clk) #1;
        check("post_rst_ready", {31'd0, bus_if.req_ready}, 32'd1);

        // Basic word store/load and sub-word loads.
        send("sw_10",  1'b1, F3_SW,  32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0);
        send("lw_10",  1'b0, F3_LW,  32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
        send("lb_13",  1'b0, F3_LB,  32'h13, 32'h0,         32'hFFFF_FFDE, 1'b0, 0);
        send("lbu_13", 1'b0, F3_LBU, 32'h13, 32'h0,         32'h0000_00DE, 1'b0, 0);
        send("lh_10",  1'b0, F3_LH,  32'h10, 32'h0,         32'hFFFF_BEEF, 1'b0, 0);
        send("lhu_12", 1'b0, F3_LHU, 32'h12, 32'h0,         32'h0000_DEAD, 1'b0, 0);

        // Byte store touches only its own lane.
        send("sb_11",  1'b1, F3_SB,  32'h11, 32'h0000_0055, 32'h0, 1'b0, 0);
        send("lw_10b", 1'b0, F3_LW,  32'h10, 32'h0,         32'hDEAD_55EF, 1'b0, 0);

        // Error cases: none may alter memory.
        send("lw_12_mis",  1'b0, F3_LW, 32'h12,  32'h0,         32'h0, 1'b1, 0);
        send("sw_100_oor", 1'b1, F3_SW, 32'h100, 32'h1111_1111, 32'h0, 1'b1, 0);
        send("ld_f3_011",  1'b0, 3'b011, 32'h10, 32'h0,         32'h0, 1'b1, 0);
        send("st_f3_100",  1'b1, 3'b100, 32'h10, 32'h2222_2222, 32'h0, 1'b1, 0);
        send("sh_11_mis",  1'b1, F3_SH, 32'h11,  32'h0000_3333, 32'h0, 1'b1, 0);
        send("lh_11_mis",  1'b0, F3_LH, 32'h11,  32'h0,         32'h0, 1'b1, 0);
        send("lw_10c",     1'b0, F3_LW, 32'h10,  32'h0,         32'hDEAD_55EF, 1'b0, 0);

        // Last valid word versus first out-of-range word.
        send("sw_fc",  1'b1, F3_SW, 32'hFC,  32'h0102_0304, 32'h0, 1'b0, 0);
        send("lw_fc",  1'b0, F3_LW, 32'hFC,  32'h0,         32'h0102_0304, 1'b0, 0);
        send("lw_100", 1'b0, F3_LW, 32'h100, 32'h0,         32'h0, 1'b1, 0);

        // Response held while the initiator stalls.
        send("lw_stall", 1'b0, F3_LW, 32'h10, 32'h0, 32'hDEAD_55EF, 1'b0, 5);

        // Half store on the upper lanes.
        send("sw_20",   1'b1, F3_SW,  32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        send("sh_22",   1'b1, F3_SH,  32'h22, 32'h0000_BEEF, 32'h0, 1'b0, 0);
        send("lw_20",   1'b0, F3_LW,  32'h20, 32'h0,         32'hBEEF_F00D, 1'b0, 0);
        send("lb_22",   1'b0, F3_LB,  32'h22, 32'h0,         32'hFFFF_FFEF, 1'b0, 0);

        // Store aborted by reset on what would have been its commit edge.
        for (int i = 0; i < 20 && !bus_if.req_ready; i++) @(posedge clk) #1;
        bus_if.req_valid  = 1'b1;
        bus_if.req_we     = 1'b1;
        bus_if.req_funct3 = F3_SW;
        bus_if.req_addr   = 32'h20;
        bus_if.req_wdata  = 32'h1234_5678;
        @(posedge clk) #1;
        bus_if.req_valid  = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;
        @(posedge clk) #1;
        check("abort_rst_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        check("abort_rst_ready", {31'd0, bus_if.req_ready}, 32'd0);
        @(posedge clk) #1;
        rst = 1'b1;
        @(posedge clk) #1;
        check("abort_post_ready", {31'd0, bus_if.req_ready}, 32'd1);
        check("abort_post_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        send("lw_20_abort", 1'b0, F3_LW, 32'h20, 32'h0, 32'hBEEF_F00D, 1'b0, 0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
